// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and helpers for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus between the operand generator, the ALU and the answer checker.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [2:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic             bad_op;

  modport master (
    output in_valid, operand1, operand2, operation, out_ready,
    input  in_ready, out_valid, result, div_by_zero, bad_op
  );

  modport slave (
    input  in_valid, operand1, operand2, operation, out_ready,
    output in_ready, out_valid, result, div_by_zero, bad_op
  );

endinterface

// File: rtl/seq_alu_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle already
// resolves the first bit so the result is ready WIDTH-1 cycles later.
module iter_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;

  logic [WIDTH:0]     src_rem, shifted, trial;
  logic [WIDTH-1:0]   src_quo, src_dvs;

  // One restoring step; a set MSB of the trial difference means it went negative.
  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? dividend_i : quo_q;
    src_dvs = start_i ? divisor_i : dvs_q;
    shifted = {src_rem[WIDTH-1:0], src_quo[WIDTH-1]};
    trial   = shifted - {1'b0, src_dvs};
    rem_d   = trial[WIDTH] ? shifted : trial;
    quo_d   = {src_quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= divisor_i;
        cnt_q  <= CNT_W'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Valid/ready ALU: single-cycle add/sub/mul, iterative div/mod, registered result and flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  seq_alu_if.slave bus_io
);

  state_e           state_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q, bad_q, out_valid_q, in_ready_q;

  logic             accept_c, div_start_c;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign accept_c    = bus_io.in_valid && in_ready_q;
  assign div_start_c = accept_c && is_div_op(bus_io.operation) && (bus_io.operand2 != '0);

  iter_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start_c),
    .dividend_i  (bus_io.operand1),
    .divisor_i   (bus_io.operand2),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            op1_q      <= bus_io.operand1;
            op2_q      <= bus_io.operand2;
            op_q       <= bus_io.operation;
            dbz_q      <= 1'b0;
            bad_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= div_start_c ? S_DIV : S_EXEC;
          end
        end
        S_EXEC: begin
          // Division ops only land here with a zero divisor.
          case (op_q)
            OP_ADD:  result_q <= op1_q + op2_q;
            OP_SUB:  result_q <= op1_q - op2_q;
            OP_MUL:  result_q <= op1_q * op2_q;
            OP_DIV, OP_MOD: begin
              result_q <= '0;
              dbz_q    <= 1'b1;
            end
            default: begin
              result_q <= '0;
              bad_q    <= 1'b1;
            end
          endcase
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DIV: begin
          if (div_done && !div_busy) begin
            result_q    <= (op_q == OP_DIV) ? div_quo : div_rem;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.in_ready    = in_ready_q;
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.result      = result_q;
  assign bus_io.div_by_zero = dbz_q;
  assign bus_io.bad_op      = bad_q;

endmodule
